// File: rtl/mul8s_dot_acc_if.sv
// Beat/result handshake bundle for the signed dot-product accumulator.
// slave = accumulator side, master = the stage driving it.
interface mul8s_dot_acc_if #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [15:0]      in_prod;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic [LEN_W-1:0]        out_count;
    logic                    out_ovf;

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_count,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_count,
        input  out_ovf
    );
endinterface

// File: rtl/mul8s_dot_acc.sv
// Saturating signed dot-product accumulator over multiplier products.
// One result register, refilled back-to-back when drained and loaded together.
module mul8s_dot_acc #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    mul8s_dot_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t state_d;

    logic signed [ACC_W-1:0] acc_q;
    logic [LEN_W-1:0]        count_q;
    logic                    ovf_q;

    logic signed [ACC_W-1:0] res_sum_q;
    logic [LEN_W-1:0]        res_count_q;
    logic                    res_ovf_q;

    logic                    out_valid;
    logic                    in_ready;
    logic                    accept;
    logic                    take;
    logic                    drain;

    logic signed [ACC_W:0]   sum_wide;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [ACC_W-1:0] sum_sat;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    ovf_inc;

    assign accept = bus.in_valid & in_ready;
    assign take   = accept & bus.in_last;
    assign drain  = out_valid & bus.out_ready;

    // One guard bit above the accumulator exposes signed overflow.
    assign sum_wide =
        {acc_q[ACC_W-1], acc_q} +
        {{(ACC_W+1-16){bus.in_prod[15]}}, bus.in_prod};

    assign sat_hi = ~sum_wide[ACC_W] & sum_wide[ACC_W-1];
    assign sat_lo = sum_wide[ACC_W] & ~sum_wide[ACC_W-1];

    always_comb begin
        sum_sat = sum_wide[ACC_W-1:0];
        unique case (1'b1)
            sat_hi:  sum_sat = SAT_MAX;
            sat_lo:  sum_sat = SAT_MIN;
            default: sum_sat = sum_wide[ACC_W-1:0];
        endcase
    end

    assign cnt_inc = (count_q == CNT_MAX) ? count_q
                                          : count_q + 1'b1;
    assign ovf_inc = ovf_q | sat_hi | sat_lo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (take)        state_d = HOLD;
                else if (accept) state_d = ACC;
            end
            ACC: begin
                if (take)        state_d = HOLD;
            end
            HOLD: begin
                if (take)        state_d = HOLD;
                else if (accept) state_d = ACC;
                else if (drain)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = ~out_valid | bus.out_ready;
    end

    // A last beat empties the running vector into the result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (take) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            acc_q   <= sum_sat;
            count_q <= cnt_inc;
            ovf_q   <= ovf_inc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_sum_q   <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else if (take) begin
            res_sum_q   <= sum_sat;
            res_count_q <= cnt_inc;
            res_ovf_q   <= ovf_inc;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = res_sum_q;
    assign bus.out_count = res_count_q;
    assign bus.out_ovf   = res_ovf_q;
endmodule

// File: tb/tb_mul8s_dot_acc.sv
// Directed checks of the saturating dot-product accumulator.
// Expected sums are worked out by hand for each vector.
module tb_mul8s_dot_acc;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    mul8s_dot_acc_if #(.ACC_W(24), .LEN_W(8)) bus ();

    mul8s_dot_acc #(.ACC_W(24), .LEN_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(
        input string             tag,
        input logic signed [31:0] obs,
        input logic signed [31:0] exp
    );
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic res(
        input string tag,
        input int    sum,
        input int    cnt,
        input int    ovf
    );
        chk({tag, "_vld"}, 32'(bus.out_valid), 1);
        chk({tag, "_sum"}, 32'($signed(bus.out_sum)), sum);
        chk({tag, "_cnt"}, 32'(bus.out_count), cnt);
        chk({tag, "_ovf"}, 32'(bus.out_ovf), ovf);
    endtask

    task automatic beat(input int p, input logic last);
        int n;
        bus.in_valid = 1'b1;
        bus.in_prod  = 16'(p);
        bus.in_last  = last;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!bus.in_ready)
            chk("rdy_wait", 32'(bus.in_ready), 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #12 reset = 1'b0;
        #1;
        chk("rst_vld", 32'(bus.out_valid), 0);
        chk("rst_rdy", 32'(bus.in_ready), 1);
        chk("rst_sum", 32'($signed(bus.out_sum)), 0);
        chk("rst_cnt", 32'(bus.out_count), 0);
        chk("rst_ovf", 32'(bus.out_ovf), 0);
        idle_cycle();

        // basic: 100 - 50 + 7
        bus.out_ready = 1'b1;
        beat(100, 1'b0);
        chk("mid_vld", 32'(bus.out_valid), 0);
        beat(-50, 1'b0);
        beat(7, 1'b1);
        res("basic", 57, 3, 0);
        idle_cycle();
        chk("drain_vld", 32'(bus.out_valid), 0);

        // backpressure
        bus.out_ready = 1'b0;
        beat(100, 1'b0);
        beat(-50, 1'b0);
        beat(7, 1'b1);
        res("bp1", 57, 3, 0);
        bus.in_valid = 1'b1;
        bus.in_prod  = -16'sd3;
        bus.in_last  = 1'b0;
        #1;
        chk("bp_rdy", 32'(bus.in_ready), 0);
        idle_cycle();
        idle_cycle();
        res("bp_hold", 57, 3, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy1", 32'(bus.in_ready), 1);
        idle_cycle();
        chk("bp_drop", 32'(bus.out_valid), 0);
        bus.in_prod = -16'sd4;
        bus.in_last = 1'b1;
        idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        res("bp2", -7, 2, 0);

        // drain and single-beat load in the same cycle
        beat(9, 1'b1);
        res("simul", 9, 1, 0);
        idle_cycle();
        chk("simul_drop", 32'(bus.out_valid), 0);

        // positive saturation, count saturates at 255
        for (int i = 0; i < 256; i++) beat(32767, 1'b0);
        beat(32767, 1'b1);
        res("satp", 8388607, 255, 1);

        // sticky overflow must not leak into the next vector
        beat(5, 1'b1);
        res("after_sat", 5, 1, 0);

        // 256 * -32768 lands exactly on the negative limit
        for (int i = 0; i < 255; i++) beat(-32768, 1'b0);
        beat(-32768, 1'b1);
        res("negb", -8388608, 255, 0);

        // reset mid-vector
        beat(1000, 1'b0);
        beat(2000, 1'b0);
        reset = 1'b1;
        #1;
        chk("arst_vld", 32'(bus.out_valid), 0);
        chk("arst_rdy", 32'(bus.in_ready), 1);
        chk("arst_sum", 32'($signed(bus.out_sum)), 0);
        chk("arst_cnt", 32'(bus.out_count), 0);
        #2 reset = 1'b0;
        idle_cycle();
        beat(-5, 1'b1);
        res("rstmid", -5, 1, 0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
